// File: rtl/am_next_addr_ctrl.sv
// Microinstruction pipeline register and next-address control for Am2909 sequencer slices.
// Decodes the pipelined opcode with a polarity-adjusted condition and an internal loop counter.
module am_next_addr_ctrl #(
  parameter int unsigned AW = 12,
  parameter int unsigned CW = 12
) (
  input  logic          CP,
  input  logic          MR,
  input  logic          PLE,
  input  logic [3:0]    UI,
  input  logic [AW-1:0] UD,
  input  logic [1:0]    USEL,
  input  logic          UPOL,
  input  logic          URE,
  input  logic [3:0]    CC,
  output logic [1:0]    S,
  output logic          FE,
  output logic          PUP,
  output logic          RE,
  output logic          ZERO,
  output logic          CI,
  output logic [1:0]    DSEL,
  output logic [AW-1:0] D_OUT,
  output logic          CNT_Z
);

  typedef enum logic [3:0] {
    OpJz   = 4'd0,  OpCjs  = 4'd1,  OpJmap = 4'd2,  OpCjp  = 4'd3,
    OpPush = 4'd4,  OpJsrp = 4'd5,  OpCjv  = 4'd6,  OpJrp  = 4'd7,
    OpRfct = 4'd8,  OpRpct = 4'd9,  OpCrtn = 4'd10, OpCjpp = 4'd11,
    OpLdct = 4'd12, OpLoop = 4'd13, OpCont = 4'd14, OpTwb  = 4'd15
  } op_e;

  localparam logic [1:0] SrcPc = 2'b00, SrcAr = 2'b01, SrcStk = 2'b10, SrcD = 2'b11;

  logic [3:0]    p_ui_q;
  logic [AW-1:0] p_ud_q;
  logic [1:0]    p_sel_q;
  logic          p_pol_q;
  logic          p_re_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] load_val;
  logic          cnt_load, cnt_dec;
  logic          pass, cz;

  if (CW > AW) begin : g_cnt_ext
    assign load_val = {{(CW - AW){1'b0}}, p_ud_q};
  end else begin : g_cnt_trunc
    assign load_val = p_ud_q[CW-1:0];
  end

  assign pass  = CC[p_sel_q] ^ p_pol_q;
  assign cz    = (cnt_q == '0);
  assign CNT_Z = cz;
  assign D_OUT = p_ud_q;

  // Pipeline and counter only advance while the pipeline is loading; hold freezes both.
  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      p_ui_q  <= '0;
      p_ud_q  <= '0;
      p_sel_q <= '0;
      p_pol_q <= 1'b0;
      p_re_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (!PLE) begin
      p_ui_q  <= UI;
      p_ud_q  <= UD;
      p_sel_q <= USEL;
      p_pol_q <= UPOL;
      p_re_q  <= URE;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_load) begin
      cnt_d = load_val;
    end else if (cnt_dec) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    S        = SrcPc;
    FE       = 1'b1;
    PUP      = 1'b0;
    RE       = p_re_q;
    ZERO     = 1'b1;
    CI       = ~PLE;
    DSEL     = 2'b00;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (op_e'(p_ui_q))
      // JZ also masks the AR load so a cleared pipeline is inert.
      OpJz: begin
        ZERO = 1'b0;
        RE   = 1'b1;
      end
      OpCjs: begin
        if (pass) begin
          S   = SrcD;
          FE  = 1'b0;
          PUP = 1'b1;
        end
      end
      OpJmap: begin
        S    = SrcD;
        DSEL = 2'b01;
      end
      OpCjp: begin
        if (pass) S = SrcD;
      end
      OpPush: begin
        FE       = 1'b0;
        PUP      = 1'b1;
        cnt_load = pass;
      end
      OpJsrp: begin
        FE  = 1'b0;
        PUP = 1'b1;
        S   = pass ? SrcD : SrcAr;
      end
      OpCjv: begin
        if (pass) begin
          S    = SrcD;
          DSEL = 2'b10;
        end
      end
      OpJrp: begin
        S = pass ? SrcD : SrcAr;
      end
      OpRfct: begin
        if (!cz) begin
          S       = SrcStk;
          cnt_dec = 1'b1;
        end else begin
          FE = 1'b0;
        end
      end
      OpRpct: begin
        if (!cz) begin
          S       = SrcD;
          cnt_dec = 1'b1;
        end
      end
      OpCrtn: begin
        if (pass) begin
          S  = SrcStk;
          FE = 1'b0;
        end
      end
      OpCjpp: begin
        if (pass) begin
          S  = SrcD;
          FE = 1'b0;
        end
      end
      OpLdct: begin
        cnt_load = 1'b1;
      end
      OpLoop: begin
        if (pass) FE = 1'b0;
        else      S  = SrcStk;
      end
      OpCont: begin
        S = SrcPc;
      end
      OpTwb: begin
        if (pass) begin
          FE = 1'b0;
        end else if (!cz) begin
          S       = SrcStk;
          cnt_dec = 1'b1;
        end else begin
          S  = SrcD;
          FE = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule
